sprite_write_arbiter: RTL and testbench
=======================================

Name: sprite_write_arbiter

Overview:
- Shares the single sprite-table write port (wea/addra/dina) between N_REQ sprite sources: player, zombies, obstacles, score.
- Each source presents a 32-bit sprite descriptor plus a slot address.
- Round-robin grant, one write per grant.
- Writes are gated to vertical blanking so the renderer never reads a half-updated table.

Parameters:
- N_REQ, 4, number of requesting sprite sources (2..8)
- ADDR_W, 3, sprite-table address width
- DESC_W, 32, descriptor width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- blank  in  1  1 = vertical blanking; table writes permitted
- req_valid  in  N_REQ  per-source write request
- req_addr  in  N_REQ*ADDR_W  per-source slot address; source i at bits [i*ADDR_W +: ADDR_W]
- req_data  in  N_REQ*DESC_W  per-source descriptor; source i at bits [i*DESC_W +: DESC_W]
- req_ack  out  N_REQ  one-cycle pulse; request i consumed
- wea  out  1  sprite-table write enable
- addra  out  ADDR_W  sprite-table write address
- dina  out  DESC_W  sprite-table write data
- busy  out  1  FSM not in IDLE
- write_count  out  8  table writes committed in the current blank period; saturates at 255

Behaviour:
- Clock and reset: single clock clk. reset is synchronous, active-high.
- Reset values: all outputs 0; FSM to IDLE; last_grant = N_REQ-1, so source 0 wins first.
- Reset mid-operation aborts any pending write. No ack is issued.
- Outputs: all registered.
- States:
  - IDLE: if blank && |req_valid, go to ARB. Else stay.
  - ARB:
    - If blank == 0, go to IDLE. No write, no ack.
    - Otherwise pick the first valid source scanning last_grant+1, last_grant+2, ... modulo N_REQ.
    - Latch the winner's index, addr and data. Go to WRITE.
    - If no source is valid (all dropped), go to IDLE.
  - WRITE:
    - wea=1, addra/dina = latched values, req_ack[winner]=1, all in the same cycle.
    - last_grant <= winner. write_count increments, saturating. Go to IDLE.
- Throughput: 3 cycles per write (IDLE, ARB, WRITE).
- Latency: first write appears 2 cycles after blank && req_valid are both seen high in IDLE.
- Handshake:
  - A source holds valid, addr and data stable until ack.
  - It may reassert valid the cycle after ack.
  - If valid drops after ARB latched it, the latched data is still written and acked. This is a protocol violation, but the behaviour is defined.
- blank falls during WRITE: the write completes. The commit is already registered.
- write_count clears to 0 on the rising edge of blank (registered edge detect).
- Simultaneous blank rise and WRITE: clear takes priority; count becomes 1 only if the write lands after the clear cycle.
- Same address from two sources in one blank: both writes happen; the later grant wins the table content.
- wea is never high while blank is 0, except in the WRITE cycle that was granted while blank was 1.

Optional Feature:
- Macro: SPRITE_ARB_DIRTY_SKIP_EN
- Defined:
  - Keep a 2^ADDR_W-entry shadow of the last written descriptor plus a per-entry valid bit. Shadow valid bits clear on reset.
  - In ARB, if shadow_valid[addr] && shadow[addr] == winner data, go to SKIP.
  - SKIP lasts one cycle: req_ack[winner]=1, wea=0, write_count unchanged, last_grant updated, then IDLE.
  - WRITE updates the shadow entry.
- Not defined: no shadow, SKIP state absent, every grant writes.

Decomposition:
- Package sprite_arb_pkg:
  - state enum: IDLE, ARB, WRITE, SKIP
  - DESC_W default
  - ADDR_W default
  - function to slice a source's addr/data from the packed buses
- Sub-module rr_priority_pick:
  - combinational round-robin picker
  - inputs: req vector, last_grant
  - outputs: grant index, any_valid

Test Plan:
- Single request: blank=1, req_valid=4'b0001, addr=0, data=32'h8012_C190 -> wea high 2 cycles later with addra=0, dina=32'h8012_C190; req_ack[0] pulses in the same cycle; write_count=1.
- Fairness: all four sources held valid for the whole blank -> grant order 0,1,2,3,0,... with one write every 3 cycles; after 12 cycles write_count=4.
- Blank gating: req_valid=4'b0010 with blank=0 for 20 cycles -> no wea, no ack. When blank rises, the write occurs 2 cycles later.
- Abort: blank falls in the ARB cycle -> no wea, no ack, FSM returns to IDLE. blank falls in the WRITE cycle -> the write completes.
- Reset mid-ARB: reset=1 for 1 cycle -> all outputs 0, no ack. The next grant goes to source 0 even if source 2 was the pending winner.
- With SPRITE_ARB_DIRTY_SKIP_EN: the same descriptor written twice to addr 3 -> second request is acked with wea=0; write_count stays at 1.

Source files
------------

// File: rtl/sprite_arb_pkg.sv
// sprite_arb_pkg: shared defaults, FSM states and bus-slicing helper for the sprite write arbiter.
package sprite_arb_pkg;
  localparam int ADDR_W_DEF = 3;
  localparam int DESC_W_DEF = 32;
  localparam int BUS_MAX = 8 * 64;
  typedef enum logic [1:0] {IDLE, ARB, WRITE, SKIP} state_e;
  function automatic logic [63:0] slice_field(input logic [BUS_MAX-1:0] bus, input int idx, input int w);
    logic [BUS_MAX-1:0] s;
    s = bus >> (idx * w);
    for (int b = 0; b < 64; b++) if (b >= w) s[b] = 1'b0;
    return s[63:0];
  endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin picker, first valid source after last.
module rr_priority_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [$clog2(N)-1:0] grant,
  output logic                 any_valid
);
  localparam int W = $clog2(N);
  always_comb begin
    grant = '0;
    for (int i = N; i >= 1; i--)
      if (req[(int'(last) + i) % N]) grant = W'((int'(last) + i) % N);
    any_valid = |req;
  end
endmodule

// File: rtl/sprite_write_arbiter.sv
// sprite_write_arbiter: round-robin share of the sprite-table write port, gated to vertical blanking.
// Define SPRITE_ARB_DIRTY_SKIP_EN to skip writes whose descriptor already matches the table.
module sprite_write_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DESC_W = DESC_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    blank,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DESC_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ack,
  output logic                    wea,
  output logic [ADDR_W-1:0]       addra,
  output logic [DESC_W-1:0]       dina,
  output logic                    busy,
  output logic [7:0]              write_count
);
  localparam int IW = $clog2(N_REQ);
  state_e state_q, state_d;
  logic [IW-1:0] last_q, last_d, win_q, win_d, pick_idx;
  logic [ADDR_W-1:0] addr_q, addr_d, pick_addr;
  logic [DESC_W-1:0] data_q, data_d, pick_data;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [7:0] cnt_q, cnt_d;
  logic wea_q, wea_d, busy_q, busy_d, blank_q, pick_any, hit;
  rr_priority_pick #(.N(N_REQ)) u_pick (
    .req(req_valid), .last(last_q), .grant(pick_idx), .any_valid(pick_any)
  );
  assign pick_addr = ADDR_W'(slice_field(BUS_MAX'(req_addr), int'(pick_idx), ADDR_W));
  assign pick_data = DESC_W'(slice_field(BUS_MAX'(req_data), int'(pick_idx), DESC_W));
`ifdef SPRITE_ARB_DIRTY_SKIP_EN
  logic [DESC_W-1:0] shadow_q [2**ADDR_W];
  logic [DESC_W-1:0] shadow_d [2**ADDR_W];
  logic [2**ADDR_W-1:0] shv_q, shv_d;
  always_comb begin
    shadow_d = shadow_q;
    shv_d = shv_q;
    if (state_q == WRITE) begin
      shadow_d[addr_q] = data_q;
      shv_d[addr_q] = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    shv_q <= reset ? '0 : shv_d;
    shadow_q <= shadow_d;
  end
  assign hit = shv_q[pick_addr] && shadow_q[pick_addr] == pick_data;
`else
  assign hit = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    win_d = win_q;
    addr_d = addr_q;
    data_d = data_q;
    case (state_q)
      IDLE: state_d = (blank && |req_valid) ? ARB : IDLE;
      ARB: begin
        if (!blank || !pick_any) state_d = IDLE;
        else begin
          win_d = pick_idx;
          addr_d = pick_addr;
          data_d = pick_data;
          state_d = hit ? SKIP : WRITE;
        end
      end
      default: begin
        last_d = win_q;
        state_d = IDLE;
      end
    endcase
    wea_d = state_d == WRITE;
    ack_d = (state_d == WRITE || state_d == SKIP) ? (N_REQ'(1) << win_d) : '0;
    busy_d = state_d != IDLE;
    // a fresh blank period clears the count even if a write commits this cycle
    cnt_d = (blank && !blank_q) ? 8'd0 : (wea_d && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= IW'(N_REQ - 1);
      win_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      ack_q <= '0;
      wea_q <= 1'b0;
      busy_q <= 1'b0;
      cnt_q <= '0;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      win_q <= win_d;
      addr_q <= addr_d;
      data_q <= data_d;
      ack_q <= ack_d;
      wea_q <= wea_d;
      busy_q <= busy_d;
      cnt_q <= cnt_d;
      blank_q <= blank;
    end
  end
  assign req_ack = ack_q;
  assign wea = wea_q;
  assign addra = addr_q;
  assign dina = data_q;
  assign busy = busy_q;
  assign write_count = cnt_q;
endmodule

// File: tb/tb_sprite_write_arbiter.sv
// tb_sprite_write_arbiter: table-driven and scoreboarded checks of the sprite write arbiter.
module tb_sprite_write_arbiter;
  localparam int N = 4, AW = 3, DW = 32;
  logic clk = 1'b0, reset, blank;
  logic [N-1:0] req_valid, req_ack;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic wea, busy;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic [7:0] write_count;
  sprite_write_arbiter #(.N_REQ(N), .ADDR_W(AW), .DESC_W(DW)) dut (
    .clk(clk), .reset(reset), .blank(blank), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ack(req_ack), .wea(wea), .addra(addra), .dina(dina),
    .busy(busy), .write_count(write_count)
  );
  always #5 clk = ~clk;
  typedef struct {logic [N-1:0] ack; logic wea; logic [AW-1:0] addr; logic [DW-1:0] data; logic [7:0] cnt;} exp_t;
  typedef struct {int src; logic [AW-1:0] addr; logic [DW-1:0] data;} vec_t;
  exp_t sbq[$];
  exp_t mon_e;
  vec_t vecs[6];
  int errors = 0, checks = 0, wea_seen = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input int src, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input int cnt);
    exp_t e;
    e.ack = N'(1) << src;
    e.wea = w;
    e.addr = a;
    e.data = d;
    e.cnt = 8'(cnt);
    sbq.push_back(e);
  endtask
  task automatic set_req(input int src, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[src*AW +: AW] = a;
    req_data[src*DW +: DW] = d;
    req_valid[src] = 1'b1;
  endtask
  task automatic wait_ack(input int src, output int n);
    n = 0;
    while (!req_ack[src] && n < 12) begin
      tick;
      n++;
    end
    if (!req_ack[src]) chk("ack_timeout", 64'(n), 64'(0));
  endtask
  always @(negedge clk) begin
    if (!reset && (wea || req_ack != '0)) begin
      if (wea) wea_seen++;
      if (sbq.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_write: got ack=%b wea=%b addr=%0d expected no activity", req_ack, wea, addra);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_ack", 64'(req_ack), 64'(mon_e.ack));
        chk("sb_wea", 64'(wea), 64'(mon_e.wea));
        chk("sb_addr", 64'(addra), 64'(mon_e.addr));
        chk("sb_data", 64'(dina), 64'(mon_e.data));
        chk("sb_count", 64'(write_count), 64'(mon_e.cnt));
      end
    end
  end
  initial begin
    int n, t, nack, ws;
    vecs[0] = '{0, 3'd0, 32'h8012_C190};
    vecs[1] = '{3, 3'd5, 32'h1111_0005};
    vecs[2] = '{1, 3'd5, 32'h2222_0005};
    vecs[3] = '{2, 3'd7, 32'hDEAD_BEEF};
    vecs[4] = '{0, 3'd2, 32'h0000_0001};
    vecs[5] = '{3, 3'd0, 32'hFFFF_FFFF};
    reset = 1'b1;
    blank = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    repeat (3) tick;
    chk("reset_outputs", {req_ack, wea, addra, dina, busy, write_count}, '0);
    reset = 1'b0;
    tick;
    blank = 1'b1;
    for (int v = 0; v < 6; v++) begin
      set_req(vecs[v].src, vecs[v].addr, vecs[v].data);
      push(vecs[v].src, 1'b1, vecs[v].addr, vecs[v].data, v + 1);
      wait_ack(vecs[v].src, n);
      chk("vec_latency", 64'(n), 64'(2));
      req_valid = '0;
      tick;
    end
    blank = 1'b0;
    repeat (2) tick;
    blank = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, AW'(i), 32'hC000_0000 + i);
    for (int k = 0; k < 260; k++) push(k % N, 1'b1, AW'(k % N), 32'hC000_0000 + k, k + 1 > 255 ? 255 : k + 1);
    t = 0;
    nack = 0;
    while (nack < 260 && t < 1000) begin
      tick;
      t++;
      if (t == 12) chk("count_after_12", 64'(write_count), 64'(4));
      for (int i = 0; i < N; i++)
        if (req_ack[i]) begin
          nack++;
          req_data[i*DW +: DW] += 4;
        end
    end
    req_valid = '0;
    chk("fair_acks", 64'(nack), 64'(260));
    chk("count_saturate", 64'(write_count), 64'(255));
    tick;
    chk("fair_drained", 64'(sbq.size()), 64'(0));
    blank = 1'b0;
    repeat (2) tick;
    ws = wea_seen;
    blank = 1'b1;
    set_req(1, 3'd4, 32'h0BAD_0001);
    tick;
    blank = 1'b0;
    tick;
    chk("abort_arb_busy", 64'(busy), 64'(0));
    chk("abort_arb_count_cleared", 64'(write_count), 64'(0));
    req_valid = '0;
    repeat (3) tick;
    chk("abort_arb_no_wea", 64'(wea_seen), 64'(ws));
    blank = 1'b1;
    set_req(2, 3'd6, 32'h5A5A_0006);
    push(2, 1'b1, 3'd6, 32'h5A5A_0006, 1);
    tick;
    tick;
    blank = 1'b0;
    tick;
    chk("blank_fall_write_done", 64'(sbq.size()), 64'(0));
    chk("blank_fall_busy", 64'(busy), 64'(0));
    req_valid = '0;
    ws = wea_seen;
    set_req(1, 3'd1, 32'h7777_0001);
    repeat (20) tick;
    chk("gated_no_wea", 64'(wea_seen), 64'(ws));
    chk("gated_no_busy", 64'(busy), 64'(0));
    blank = 1'b1;
    push(1, 1'b1, 3'd1, 32'h7777_0001, 1);
    wait_ack(1, n);
    chk("gated_latency", 64'(n), 64'(2));
    req_valid = '0;
    tick;
    ws = wea_seen;
    set_req(3, 3'd3, 32'h3333_0003);
    tick;
    req_valid = '0;
    tick;
    chk("drop_busy", 64'(busy), 64'(0));
    repeat (3) tick;
    chk("drop_no_wea", 64'(wea_seen), 64'(ws));
    set_req(0, 3'd2, 32'hAAAA_0000);
    set_req(2, 3'd4, 32'hAAAA_0002);
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("reset_mid_arb", {req_ack, wea, addra, dina, busy, write_count}, '0);
    push(0, 1'b1, 3'd2, 32'hAAAA_0000, 1);
    wait_ack(0, n);
    chk("post_reset_src0_latency", 64'(n), 64'(2));
    req_valid[0] = 1'b0;
    push(2, 1'b1, 3'd4, 32'hAAAA_0002, 2);
    wait_ack(2, n);
    chk("post_reset_src2_latency", 64'(n), 64'(3));
    req_valid = '0;
    tick;
`ifdef SPRITE_ARB_DIRTY_SKIP_EN
    set_req(0, 3'd3, 32'h1234_5678);
    push(0, 1'b1, 3'd3, 32'h1234_5678, 3);
    wait_ack(0, n);
    req_valid = '0;
    tick;
    set_req(0, 3'd3, 32'h1234_5678);
    push(0, 1'b0, 3'd3, 32'h1234_5678, 3);
    wait_ack(0, n);
    chk("skip_latency", 64'(n), 64'(2));
    req_valid = '0;
    tick;
    chk("skip_count", 64'(write_count), 64'(3));
`endif
    repeat (4) tick;
    chk("final_drained", 64'(sbq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
